// File: rtl/elastic_pipeline_buffer_if.sv
// Valid/ready bundle around one elastic pipeline buffer.
// The master side is the surrounding pipeline, the slave side the buffer.
interface elastic_pipeline_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             almost_full;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, almost_full
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, almost_full
    );
endinterface

// File: rtl/elastic_pipeline_buffer.sv
// Circular-buffer skid stage with explicit occupancy count and flush.
// Handshake outputs depend only on registered state, never on out_ready.
module elastic_pipeline_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int AFULL = DEPTH - 1
) (
    input logic clk,
    input logic reset_n,
    elastic_pipeline_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign bus.in_ready    = (count != CW'(DEPTH));
    assign bus.out_valid   = (count != '0);
    assign bus.out_data    = mem[rp];
    assign bus.level       = count;
    assign bus.almost_full = (int'(count) >= AFULL);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            // Squash drops pointers only; stale array contents are harmless.
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= bus.in_data;
                wp      <= next_ptr(wp);
            end
            if (pop) begin
                rp <= next_ptr(rp);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_elastic_pipeline_buffer.sv
// Scoreboard bench: five buffers of depth 1..5 share one directed and
// randomized stimulus stream; a queue per buffer is the reference FIFO.
module tb_elastic_pipeline_buffer;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] iv;
    logic [N-1:0] ordy;
    logic [N-1:0] fl;
    logic [N-1:0] ir;
    logic [N-1:0] ov;
    logic [N-1:0] af;
    logic [31:0]  din [N];
    logic [31:0]  od [N];
    logic [3:0]   lvl [N];
    logic [31:0]  sb [N][$];
    int           checks = 0;
    int           errors = 0;
    logic [31:0]  seq;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : u
        elastic_pipeline_buffer_if #(.WIDTH(32), .DEPTH(g + 1)) bus ();

        assign bus.flush     = fl[g];
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = din[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]  = bus.in_ready;
        assign ov[g]  = bus.out_valid;
        assign od[g]  = bus.out_data;
        assign lvl[g] = 4'(bus.level);
        assign af[g]  = bus.almost_full;

        elastic_pipeline_buffer #(.WIDTH(32), .DEPTH(g + 1)) dut (
            .clk(clk),
            .reset_n(reset_n),
            .bus(bus)
        );
    end

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s depth=%0d t=%0t: got %h expected %h",
                     nm, k + 1, $time, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [31:0] d);
        for (int k = 0; k < N; k++) begin
            iv[k]   = v;
            ordy[k] = r;
            fl[k]   = f;
            din[k]  = d;
        end
    endtask

    // Acceptance is decided from the reference occupancy of this cycle;
    // the scoreboard entry is committed at the edge that performs it.
    task automatic tick();
        logic [N-1:0] acc;
        for (int k = 0; k < N; k++) begin
            acc[k] = reset_n && iv[k] && !fl[k] && (sb[k].size() < k + 1);
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (fl[k] && reset_n) sb[k].delete();
            else if (acc[k]) sb[k].push_back(din[k]);
        end
        #1;
    endtask

    task automatic run(input int n, input logic v, input logic r);
        for (int i = 0; i < n; i++) begin
            drive(v, r, 1'b0, seq);
            seq = seq + 1;
            tick();
        end
    endtask

    task automatic reset_checks();
        for (int k = 0; k < N; k++) begin
            chk("rst_in_ready", k, 32'(ir[k]), 32'd1);
            chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_out_data", k, od[k], 32'd0);
            chk("rst_level", k, 32'(lvl[k]), 32'd0);
            chk("rst_almost_full", k, 32'(af[k]), 32'(k == 0));
        end
    endtask

    // Monitor: compares every buffer against its reference queue
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            automatic int n = sb[k].size();
            chk("in_ready", k, 32'(ir[k]), 32'(n < k + 1));
            chk("out_valid", k, 32'(ov[k]), 32'(n != 0));
            chk("level", k, 32'(lvl[k]), 32'(n));
            chk("almost_full", k, 32'(af[k]), 32'(n >= k));
            if (n != 0) begin
                chk("out_data", k, od[k], sb[k][0]);
                if (ordy[k] && !fl[k] && reset_n) void'(sb[k].pop_front());
            end
        end
    end

    initial begin
        seq = 32'h1000;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #1 reset_n = 1'b0;
        #2 reset_checks();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0x11..0x44 and hold off the consumer
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h11 * (i + 1));
            tick();
        end
        chk("fill_level", 3, 32'(lvl[3]), 32'd4);
        chk("fill_in_ready", 3, 32'(ir[3]), 32'd0);
        chk("fill_almost_full", 3, 32'(af[3]), 32'd1);
        run(6, 1'b0, 1'b1);
        chk("drain_out_valid", 3, 32'(ov[3]), 32'd0);

        // Full with out_ready: pop only, held payload enters next cycle
        run(5, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'hC0DE);
        tick();
        chk("fullpop_level", 3, 32'(lvl[3]), 32'd3);
        chk("fullpop_in_ready", 3, 32'(ir[3]), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'hC0DE);
        tick();
        chk("held_accept_level", 3, 32'(lvl[3]), 32'd4);
        run(7, 1'b0, 1'b1);

        // Steady push/pop at level 2; depth 3 wraps several times
        run(2, 1'b1, 1'b0);
        run(20, 1'b1, 1'b1);
        chk("pushpop_level", 2, 32'(lvl[2]), 32'd2);
        run(6, 1'b0, 1'b1);

        // Flush at level 3 with concurrent push and pop
        run(3, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'hDEAD);
        tick();
        chk("flush_level", 3, 32'(lvl[3]), 32'd0);
        chk("flush_out_valid", 3, 32'(ov[3]), 32'd0);
        chk("flush_in_ready", 3, 32'(ir[3]), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'hBEEF);
        tick();
        chk("post_flush_valid", 3, 32'(ov[3]), 32'd1);
        chk("post_flush_head", 3, od[3], 32'hBEEF);
        run(6, 1'b0, 1'b1);

        // Reset mid-traffic with two entries stored
        drive(1'b1, 1'b0, 1'b0, 32'h77);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h88);
        tick();
        chk("pre_reset_level", 3, 32'(lvl[3]), 32'd2);
        #2;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < N; k++) sb[k].delete();
        #1 reset_checks();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent random traffic per buffer
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                iv[k]   = 1'($urandom_range(1));
                ordy[k] = 1'($urandom_range(1));
                fl[k]   = ($urandom_range(96) == 0);
                din[k]  = $urandom;
            end
            tick();
        end
        run(8, 1'b0, 1'b1);
        for (int k = 0; k < N; k++) begin
            chk("final_empty", k, 32'(sb[k].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
